// File: rtl/serial_sub4b_pkg.sv
// ============================================================================
// serial_sub4b_pkg : shared FSM encoding and default width for serial_sub4b
// Revision 1.0
// ============================================================================
`default_nettype none

package serial_sub4b_pkg;

   localparam int N_DEFAULT = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold the value N without wrapping.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub4b_full_subtractor.sv
// ============================================================================
// full_subtractor : one-bit a - b - bin cell, purely combinational
// Revision 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub4b.sv
// ============================================================================
// serial_sub4b : bit-serial subtractor D = A - B, LSB first, one bit per clock
// Revision 1.0
// ============================================================================
`default_nettype none

module serial_sub4b
   import serial_sub4b_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic [N:0]   D,
   output logic         busy,
   output logic         done
);

   localparam int CNT_W = cnt_width(N);

   state_t             state;
   state_t             state_nx;
   logic [N-1:0]       a_sh;
   logic [N-1:0]       b_sh;
   logic               borrow;
   logic [CNT_W-1:0]   cnt;
   logic               diff_bit;
   logic               borrow_nx;
   logic               last_bit;

   full_subtractor u_fs (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .bin  (borrow),
      .d    (diff_bit),
      .bout (borrow_nx)
   );

   assign last_bit = (cnt == CNT_W'(N - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_bit) state_nx = ST_DONE;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // D right-shifts so the first (LSB) difference bit ends up at D[0].
   always_ff @(posedge clock) begin
      if (reset) begin
         a_sh   <= '0;
         b_sh   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         D      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  a_sh   <= A;
                  b_sh   <= B;
                  borrow <= 1'b0;
                  cnt    <= '0;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               borrow <= borrow_nx;
               cnt    <= cnt + 1'b1;
               if (last_bit) begin
                  D <= {borrow_nx, diff_bit, D[N-1:1]};
               end else begin
                  D <= {D[N], diff_bit, D[N-1:1]};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub4b.sv
// ============================================================================
// tb_serial_sub4b : vector table, exhaustive/random ops and corner sequences
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_serial_sub4b;

   localparam int N = 4;

   logic         clock;
   logic         reset;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N:0]   D;
   logic         busy;
   logic         done;

   int n_checks;
   int n_fail;
   int done_total;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N:0]   d;
   } vec_t;

   vec_t tbl[8];

   serial_sub4b #(.N(N)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .A     (A),
      .B     (B),
      .D     (D),
      .busy  (busy),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (done === 1'b1) done_total++;
   end

   // Reference: (N+1)-bit two's complement of the plain integer difference.
   function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
      int diff;
      diff = int'(a) - int'(b);
      return (N+1)'(diff);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Launches one operation, then checks latency, busy length, result,
   // single done pulse and that D holds once back in IDLE.
   task automatic op_and_check(input string tag, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N:0] exp);
      int lat;
      int bcyc;
      int base;
      logic [N:0] got;
      base = done_total;
      @(negedge clock);
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat  = 0;
      bcyc = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) bcyc++;
         tick();
         lat++;
      end
      got = D;
      check({tag, " result"}, 32'(got), 32'(exp));
      check({tag, " latency"}, 32'(lat), 32'(N));
      check({tag, " busy_cycles"}, 32'(bcyc), 32'(N));
      check({tag, " busy_in_done"}, 32'(busy), 32'(0));
      tick();
      check({tag, " done_pulse_width"}, 32'(done), 32'(0));
      check({tag, " done_count"}, 32'(done_total - base), 32'(1));
      check({tag, " d_hold"}, 32'(D), 32'(exp));
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      done_total = 0;
      reset = 1'b1;
      start = 1'b1;
      A = 4'd9;
      B = 4'd3;

      tbl[0] = '{a: 4'd9,  b: 4'd3,  d: 5'b00110};
      tbl[1] = '{a: 4'd3,  b: 4'd9,  d: 5'b11010};
      tbl[2] = '{a: 4'd0,  b: 4'd15, d: 5'b10001};
      tbl[3] = '{a: 4'd15, b: 4'd1,  d: 5'b01110};
      tbl[4] = '{a: 4'd0,  b: 4'd0,  d: 5'b00000};
      tbl[5] = '{a: 4'd15, b: 4'd15, d: 5'b00000};
      tbl[6] = '{a: 4'd15, b: 4'd0,  d: 5'b01111};
      tbl[7] = '{a: 4'd0,  b: 4'd1,  d: 5'b11111};

      // Reset held two cycles with start high: nothing may start.
      tick();
      tick();
      check("reset D", 32'(D), 32'(0));
      check("reset busy", 32'(busy), 32'(0));
      check("reset done", 32'(done), 32'(0));
      @(negedge clock);
      reset = 1'b0;
      start = 1'b0;
      tick();
      check("post_reset busy", 32'(busy), 32'(0));
      check("post_reset D", 32'(D), 32'(0));

      for (int i = 0; i < 8; i++) begin
         op_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].d);
      end

      // Start and operand changes during RUN and DONE are ignored.
      begin
         int base;
         int lat;
         base = done_total;
         @(negedge clock);
         A = 4'd9;
         B = 4'd3;
         start = 1'b1;
         tick();
         start = 1'b0;
         tick();
         tick();
         @(negedge clock);
         start = 1'b1;
         A = 4'd0;
         B = 4'd15;
         lat = 2;
         while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
         end
         check("ignore latency", 32'(lat), 32'(N));
         check("ignore result", 32'(D), 32'(5'b00110));
         @(negedge clock);
         start = 1'b0;
         for (int i = 0; i < 6; i++) tick();
         check("ignore busy", 32'(busy), 32'(0));
         check("ignore done_count", 32'(done_total - base), 32'(1));
         check("ignore hold", 32'(D), 32'(5'b00110));
      end

      // Reset after two RUN edges aborts with no done pulse.
      begin
         int base;
         base = done_total;
         @(negedge clock);
         A = 4'd15;
         B = 4'd1;
         start = 1'b1;
         tick();
         start = 1'b0;
         tick();
         tick();
         @(negedge clock);
         reset = 1'b1;
         tick();
         check("abort D", 32'(D), 32'(0));
         check("abort busy", 32'(busy), 32'(0));
         check("abort done", 32'(done), 32'(0));
         @(negedge clock);
         reset = 1'b0;
         for (int i = 0; i < 6; i++) tick();
         check("abort no_done", 32'(done_total - base), 32'(0));
         op_and_check("after_abort", 4'd15, 4'd1, 5'b01110);
      end

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            op_and_check($sformatf("exh_%0d_%0d", a, b), 4'(a), 4'(b), model(4'(a), 4'(b)));
         end
      end

      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] ra;
         logic [N-1:0] rb;
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         op_and_check($sformatf("rnd%0d", i), ra, rb, model(ra, rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
